// File: rtl/reduce_unit_sequencer.sv
// Frame-level controller in front of the vector scalar reduce unit.
// Registers the beat stream (latency 1), tags each beat with the active mode,
// applies mode writes only at frame boundaries, caps frame length and keeps
// debug counters plus sticky error flags.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no frame open; next valid beat opens one (unless eof)
// IN_FRAME | frame open; leaves on eof or on the forced length cap
module reduce_unit_sequencer #(
  parameter int N             = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_FRAME_LEN = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         eof_in,
  input  logic [DATA_WIDTH*N-1:0]      vector_in,
  input  logic                         cfg_wr,
  input  logic [7:0]                   cfg_data,
  output logic                         red_valid,
  output logic                         red_eof,
  output logic [DATA_WIDTH*N-1:0]      red_vector,
  output logic [7:0]                   red_conf_byte,
  output logic                         cfg_pending,
  output logic                         in_frame,
  output logic [CNT_WIDTH-1:0]         frame_cnt,
  output logic [CNT_WIDTH-1:0]         vec_cnt,
  output logic                         err_illegal_mode,
  output logic                         err_overlength
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(MAX_FRAME_LEN - 1);

  state_t      state, state_nxt;
  logic        close, forced_close, boundary, cfg_legal;
  logic [7:0]  active_conf, pending_conf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame close / boundary decode and next-state logic.
  always_comb begin
    state_nxt    = state;
    close        = 1'b0;
    forced_close = 1'b0;
    boundary     = 1'b0;
    cfg_legal    = (cfg_data == 8'd0) || (cfg_data == 8'd1);
    close        = valid_in && (eof_in || (vec_cnt == LAST_IDX));
    forced_close = valid_in && !eof_in && (vec_cnt == LAST_IDX);
    boundary     = close || ((state == IDLE) && !valid_in);
    case (state)
      IDLE:     if (valid_in && !close) state_nxt = IN_FRAME;
      IN_FRAME: if (close)              state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  assign in_frame = (state == IN_FRAME);

  // Beat pipeline stage toward the reduce unit; data and mode hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      red_valid     <= 1'b0;
      red_eof       <= 1'b0;
      red_vector    <= '0;
      red_conf_byte <= 8'd1;
    end else begin
      red_valid <= valid_in;
      red_eof   <= close;
      if (valid_in) begin
        red_vector    <= vector_in;
        red_conf_byte <= active_conf;
      end
    end
  end

  // Frame and beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt   <= '0;
      frame_cnt <= '0;
    end else if (valid_in) begin
      if (close) begin
        vec_cnt   <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else begin
        vec_cnt   <= vec_cnt + 1'b1;
      end
    end
  end

  // Mode staging: legal writes apply at once on a boundary, else wait for one.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_conf  <= 8'd1;
      pending_conf <= 8'd0;
      cfg_pending  <= 1'b0;
    end else if (cfg_wr && cfg_legal) begin
      if (boundary) begin
        active_conf <= cfg_data;
        cfg_pending <= 1'b0;
      end else begin
        pending_conf <= cfg_data;
        cfg_pending  <= 1'b1;
      end
    end else if (boundary && cfg_pending) begin
      active_conf <= pending_conf;
      cfg_pending <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal_mode <= 1'b0;
      err_overlength   <= 1'b0;
    end else begin
      if (cfg_wr && !cfg_legal) err_illegal_mode <= 1'b1;
      if (forced_close)         err_overlength   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reduce_unit_sequencer.sv
// Directed bench for reduce_unit_sequencer with a scoreboard: each driven beat
// pushes its expected reduce-unit output; a negedge monitor pops and compares.
module tb_reduce_unit_sequencer;
  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int MFL = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst, valid_in, eof_in, cfg_wr;
  logic [DW*N-1:0] vector_in;
  logic [7:0] cfg_data;
  logic red_valid, red_eof, cfg_pending, in_frame, err_illegal_mode, err_overlength;
  logic [DW*N-1:0] red_vector;
  logic [7:0] red_conf_byte;
  logic [CW-1:0] frame_cnt, vec_cnt;

  typedef struct {
    logic [DW*N-1:0] vec;
    logic            eof;
    logic [7:0]      conf;
    int              due;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cycle = 0;

  reduce_unit_sequencer #(.N(N), .DATA_WIDTH(DW), .MAX_FRAME_LEN(MFL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .eof_in(eof_in), .vector_in(vector_in),
    .cfg_wr(cfg_wr), .cfg_data(cfg_data), .red_valid(red_valid), .red_eof(red_eof),
    .red_vector(red_vector), .red_conf_byte(red_conf_byte), .cfg_pending(cfg_pending),
    .in_frame(in_frame), .frame_cnt(frame_cnt), .vec_cnt(vec_cnt),
    .err_illegal_mode(err_illegal_mode), .err_overlength(err_overlength));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [DW*N-1:0] mkvec(input int base);
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented beat against the scoreboard head.
  always @(negedge clk) begin
    if (red_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat: red_valid=1 with empty scoreboard at cycle %0d", cycle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("beat_vector", red_vector[31:0] ^ red_vector[DW*N-1 -: 32], e.vec[31:0] ^ e.vec[DW*N-1 -: 32]);
        tests++;
        if (red_vector !== e.vec) begin
          fails++;
          $display("FAIL beat_vector_full: got %0h expected %0h", red_vector, e.vec);
        end
        chk("beat_eof", 32'(red_eof), 32'(e.eof));
        chk("beat_conf", 32'(red_conf_byte), 32'(e.conf));
        chk("beat_latency", cycle, e.due);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cycle) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++; fails++;
      $display("FAIL missing_beat: red_valid=0 expected beat due at cycle %0d", e.due);
    end
  end

  task automatic idle(input logic wr = 1'b0, input logic [7:0] d = 8'd0);
    @(negedge clk);
    valid_in  = 1'b0;
    eof_in    = 1'b1;
    vector_in = mkvec(999);
    cfg_wr    = wr;
    cfg_data  = d;
  endtask

  task automatic beat(input int base, input logic e, input logic xe, input logic [7:0] xc,
                      input logic wr = 1'b0, input logic [7:0] d = 8'd0);
    exp_t x;
    @(negedge clk);
    valid_in  = 1'b1;
    eof_in    = e;
    vector_in = mkvec(base);
    cfg_wr    = wr;
    cfg_data  = d;
    x.vec  = mkvec(base);
    x.eof  = xe;
    x.conf = xc;
    x.due  = cycle + 1;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; eof_in = 1'b0; cfg_wr = 1'b0; cfg_data = 8'd0;
    vector_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_red_valid", 32'(red_valid), 0);
    chk("rst_red_eof", 32'(red_eof), 0);
    chk("rst_red_conf", 32'(red_conf_byte), 1);
    chk("rst_red_vector_zero", 32'(red_vector == '0), 1);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_vec_cnt", 32'(vec_cnt), 0);
    chk("rst_in_frame", 32'(in_frame), 0);
    chk("rst_cfg_pending", 32'(cfg_pending), 0);
    rst = 1'b0;

    // 3-beat frame, default mode 1
    beat(1, 0, 0, 1);
    beat(11, 0, 0, 1);
    chk("f1_vec_cnt_mid", 32'(vec_cnt), 1);
    chk("f1_in_frame_mid", 32'(in_frame), 1);
    beat(21, 1, 1, 1);
    idle();
    chk("f1_frame_cnt", 32'(frame_cnt), 1);
    chk("f1_vec_cnt_end", 32'(vec_cnt), 0);
    chk("f1_in_frame_end", 32'(in_frame), 0);

    // mid-frame write of mode 0 waits for the frame end
    beat(31, 0, 0, 1);
    beat(41, 0, 0, 1, 1'b1, 8'd0);
    beat(51, 0, 0, 1);
    chk("f2_cfg_pending", 32'(cfg_pending), 1);
    beat(61, 1, 1, 1);
    idle();
    chk("f2_cfg_pending_clr", 32'(cfg_pending), 0);
    chk("f2_frame_cnt", 32'(frame_cnt), 2);
    beat(71, 0, 0, 0);
    beat(81, 1, 1, 0);
    idle();
    chk("f3_frame_cnt", 32'(frame_cnt), 3);

    // idle writes bypass; mid-frame last write wins
    idle(1'b1, 8'd0);
    idle(1'b1, 8'd1);
    chk("idle_wr0_no_pending", 32'(cfg_pending), 0);
    idle();
    chk("idle_wr1_no_pending", 32'(cfg_pending), 0);
    beat(91, 0, 0, 1, 1'b1, 8'd0);
    beat(101, 0, 0, 1, 1'b1, 8'd1);
    beat(111, 1, 1, 1);
    chk("f4_cfg_pending", 32'(cfg_pending), 1);
    idle();
    chk("f4_cfg_pending_clr", 32'(cfg_pending), 0);
    chk("f4_frame_cnt", 32'(frame_cnt), 4);
    beat(121, 1, 1, 1);
    idle();
    chk("single_beat_in_frame", 32'(in_frame), 0);
    chk("single_beat_frame_cnt", 32'(frame_cnt), 5);

    // illegal mode write
    idle(1'b1, 8'h05);
    idle();
    chk("illegal_err", 32'(err_illegal_mode), 1);
    chk("illegal_no_pending", 32'(cfg_pending), 0);
    beat(131, 1, 1, 1);
    idle();
    chk("f6_frame_cnt", 32'(frame_cnt), 6);

    // overlength: 6 beats, eof on beat 6, cap of 4; pending mode 0 lands at forced close
    beat(141, 0, 0, 1);
    beat(151, 0, 0, 1, 1'b1, 8'd0);
    beat(161, 0, 0, 1);
    chk("ovl_err_before", 32'(err_overlength), 0);
    beat(171, 0, 1, 1);
    beat(181, 0, 0, 0);
    chk("ovl_err_set", 32'(err_overlength), 1);
    chk("ovl_vec_cnt_reset", 32'(vec_cnt), 0);
    chk("ovl_frame_cnt_mid", 32'(frame_cnt), 7);
    beat(191, 1, 1, 0);
    idle();
    chk("ovl_frame_cnt", 32'(frame_cnt), 8);
    chk("ovl_err_sticky", 32'(err_overlength), 1);

    // reset mid-frame with a pending write
    beat(201, 0, 0, 0);
    beat(211, 0, 0, 0, 1'b1, 8'd0);
    @(negedge clk);
    chk("pre_rst_pending", 32'(cfg_pending), 1);
    chk("pre_rst_illegal_sticky", 32'(err_illegal_mode), 1);
    rst = 1'b1; valid_in = 1'b0; eof_in = 1'b0; cfg_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_red_valid", 32'(red_valid), 0);
    chk("mrst_red_eof", 32'(red_eof), 0);
    chk("mrst_red_conf", 32'(red_conf_byte), 1);
    chk("mrst_frame_cnt", 32'(frame_cnt), 0);
    chk("mrst_vec_cnt", 32'(vec_cnt), 0);
    chk("mrst_pending", 32'(cfg_pending), 0);
    chk("mrst_in_frame", 32'(in_frame), 0);
    chk("mrst_err_illegal", 32'(err_illegal_mode), 0);
    chk("mrst_err_ovl", 32'(err_overlength), 0);
    idle();
    beat(221, 0, 0, 1);
    beat(231, 1, 1, 1);
    idle();
    chk("post_rst_frame_cnt", 32'(frame_cnt), 1);
    idle();
    idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
